seq_comp_ctrl: RTL and testbench
================================

// Module: seq_comp_ctrl
// PURPOSE
//   Sequencer for the bit-serial magnitude comparator (seq_comp datapath).
//   - Accepts two parallel WIDTH-bit operands on a start/busy/done handshake.
//   - Clears the comparator, then streams the operand bits LSB-first, one bit per clock.
//   - Captures the comparator's gt/eq/lt decision on the MSB cycle and holds it as a registered result.
//   - Sits between the parallel register-file side and the serial comparator instance.
// PARAMETERS
//   WIDTH  8  operand width in bits; legal range 1..64
//   CNT_W  6  bit-counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request a compare; sampled only in IDLE
//   a_in       in   WIDTH  operand A, sampled with start
//   b_in       in   WIDTH  operand B, sampled with start
//   busy       out  1      high in CLEAR and SHIFT
//   done       out  1      one-cycle pulse; result registers valid from this cycle
//   gt         out  1      registered result A>B
//   eq         out  1      registered result A==B
//   lt         out  1      registered result A<B
//   cmp_err    out  1      captured comparator outputs were not one-hot; sticky until next start
//   ser_a      out  1      serial bit of A to comparator input A
//   ser_b      out  1      serial bit of B to comparator input B
//   cmp_rst_n  out  1      active-low clear to comparator flops (its 'reset' input)
//   cmp_gt     in   1      comparator gt, combinational on current bit and stored state
//   cmp_eq     in   1      comparator eq
//   cmp_lt     in   1      comparator lt
// BEHAVIOUR
//   Reset (async, reset=1)
//     - state=IDLE, shift registers and counter = 0.
//     - busy=0, done=0, gt=0, eq=1, lt=0, cmp_err=0.
//     - ser_a=ser_b=0, cmp_rst_n=0 (comparator held clear).
//   FSM states: IDLE -> CLEAR -> SHIFT -> DONE -> IDLE
//   IDLE
//     - cmp_rst_n=0.
//     - Edge with start=1: latch a_in/b_in into shift registers, cnt=0, clear cmp_err, go to CLEAR.
//     - Result registers are held.
//   CLEAR (1 cycle)
//     - cmp_rst_n=0, ser_a=ser_b=0; comparator flops clear at this edge.
//     - Go to SHIFT.
//   SHIFT (exactly WIDTH cycles)
//     - cmp_rst_n=1.
//     - Cycle i (i=0..WIDTH-1) drives ser_a=A[i], ser_b=B[i]; both shift registers shift right at each edge.
//     - cnt increments at each edge.
//     - At the edge ending cycle cnt==WIDTH-1: gt/eq/lt <= cmp_gt/cmp_eq/cmp_lt,
//       cmp_err <= !(exactly one of the three high); go to DONE.
//   DONE (1 cycle)
//     - done=1, busy=0, cmp_rst_n=0; start is ignored in this cycle.
//     - Go to IDLE.
//   Latency
//     - start sampled at edge 0 -> done high in cycle WIDTH+2.
//     - Minimum start-to-start spacing is WIDTH+3 cycles.
//   Boundary conditions
//     - start while busy or done: ignored, no queuing, operands not re-sampled.
//     - a_in/b_in may change after the start edge without effect.
//     - WIDTH=1: SHIFT lasts one cycle; capture happens on that cycle.
//     - Reset asserted mid-CLEAR/SHIFT: abort immediately to reset values; no done pulse.
//     - Equal operands: comparator stays in its eq state; result eq=1.
//     - Results remain stable until the next capture edge, including while busy.
//   Arithmetic: unsigned magnitude only; the most significant differing bit decides.
// TESTING
//   Bench pairs this block with a behavioural LSB-first comparator model (state bits GT/LT).
//   1. WIDTH=8, A=0x5A, B=0x5A, start pulse -> done at cycle 10; eq=1, gt=0, lt=0, cmp_err=0.
//   2. A=0x80, B=0x7F -> gt=1; MSB overrides the lower bits, which all favour B.
//   3. A=0x01, B=0x02 -> lt=1; then A=0xFF, B=0x00 back-to-back at the earliest start -> gt=1.
//   4. start held high through an operation with new a_in/b_in -> result reflects only the first
//      operands; second compare begins only after returning to IDLE.
//   5. Assert reset at SHIFT cycle 3 -> busy=0, eq=1, done never pulses;
//      the next compare completes correctly.
//   6. Model forced to drive gt=eq=1 on the MSB cycle -> cmp_err=1; cleared at the next start.

Source files
------------

// File: rtl/seq_comp_ctrl.sv
// Sequencer for the bit-serial magnitude comparator: loads parallel operands,
// clears the comparator, streams bits LSB-first and registers gt/eq/lt.
module seq_comp_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             cmp_err,
    output logic             ser_a,
    output logic             ser_b,
    output logic             cmp_rst_n,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        cmp_rst_n = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                cmp_rst_n = 1'b1;
                ser_a     = sh_a[0];
                ser_b     = sh_b[0];
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Result flags change only on the MSB capture edge; held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            gt      <= 1'b0;
            eq      <= 1'b1;
            lt      <= 1'b0;
            cmp_err <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                sh_a    <= a_in;
                sh_b    <= b_in;
                cnt     <= '0;
                cmp_err <= 1'b0;
            end
            if (state == S_SHIFT) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    gt      <= cmp_gt;
                    eq      <= cmp_eq;
                    lt      <= cmp_lt;
                    cmp_err <= !$onehot({cmp_gt, cmp_eq, cmp_lt});
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_comp_ctrl.sv
// Bench for seq_comp_ctrl: behavioural LSB-first comparator plus an
// arithmetic reference for the final unsigned compare result.
module tb_seq_comp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy, done, gt, eq, lt, cmp_err;
    logic         ser_a, ser_b, cmp_rst_n;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic         m_gt, m_lt, force_err;
    logic         raw_gt, raw_lt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    seq_comp_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .cmp_err   (cmp_err),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .cmp_rst_n (cmp_rst_n),
        .cmp_gt    (cmp_gt),
        .cmp_eq    (cmp_eq),
        .cmp_lt    (cmp_lt)
    );

    always #5 clk = ~clk;

    // Serial comparator: the newest differing bit overrides stored state.
    always_comb begin
        raw_gt = (ser_a & ~ser_b) | ((ser_a ~^ ser_b) & m_gt);
        raw_lt = (~ser_a & ser_b) | ((ser_a ~^ ser_b) & m_lt);
        cmp_gt = raw_gt | force_err;
        cmp_eq = (~raw_gt & ~raw_lt) | force_err;
        cmp_lt = raw_lt & ~force_err;
    end

    always @(posedge clk) begin
        if (!cmp_rst_n) begin
            m_gt <= 1'b0;
            m_lt <= 1'b0;
        end else begin
            m_gt <= raw_gt;
            m_lt <= raw_lt;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit frc);
        logic [2:0] prev;
        logic [2:0] exp_r;
        int n;
        @(posedge clk); #1;
        prev = {gt, eq, lt};
        a_in = a;
        b_in = b;
        start = 1'b1;
        force_err = frc;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        chk("busy_c1", busy, 1);
        chk("held_c1", {gt, eq, lt}, prev);
        chk("err_clr", cmp_err, 0);
        n = 1;
        while (!done && n < 40) begin
            if (n >= 2 && n <= W + 1)
                chk("ser", {ser_a, ser_b}, {a[n-2], b[n-2]});
            @(posedge clk); #1;
            n++;
        end
        force_err = 1'b0;
        exp_r = frc ? 3'b110 : {a > b, a == b, a < b};
        chk("latency", n, W + 2);
        chk("result", {gt, eq, lt}, exp_r);
        chk("cmp_err", cmp_err, frc);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit seen;
        int n;
        reset = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        force_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", {gt, eq, lt}, 3'b010);
        chk("rst_err", cmp_err, 0);
        chk("rst_ser", {ser_a, ser_b}, 2'b00);
        chk("rst_crst", cmp_rst_n, 0);
        reset = 1'b0;

        run_cmp(8'h5A, 8'h5A, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b0);
        run_cmp(8'h01, 8'h02, 1'b0);
        run_cmp(8'hFF, 8'h00, 1'b0);

        // start held high, operands changed mid-operation
        @(posedge clk); #1;
        a_in = 8'h10;
        b_in = 8'h20;
        start = 1'b1;
        @(posedge clk); #1;
        a_in = 8'hF0;
        b_in = 8'h0F;
        repeat (W + 1) begin
            @(posedge clk); #1;
        end
        chk("hold_done", done, 1);
        chk("hold_res", {gt, eq, lt}, 3'b001);
        @(posedge clk); #1;
        chk("hold_idle", busy, 0);
        @(posedge clk); #1;
        chk("hold_restart", busy, 1);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold2_res", {gt, eq, lt}, 3'b100);
        chk("hold2_err", cmp_err, 0);

        // reset in the middle of SHIFT
        @(posedge clk); #1;
        a_in = 8'h33;
        b_in = 8'h44;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res", {gt, eq, lt}, 3'b010);
        chk("abort_crst", cmp_rst_n, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= done;
        end
        chk("abort_nodone", seen, 0);
        run_cmp(8'h33, 8'h44, 1'b0);

        run_cmp(8'h12, 8'h34, 1'b1);
        run_cmp(8'hC3, 8'hC3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_cmp(ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
